// File: rtl/fma16_vector_recorder.sv
//------------------------------------------------------------------------------
// fma16_vector_recorder : packs live fma16 operations into 76-bit vector
// records, buffers them in a ring FIFO and streams them out on a dump port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fma16_vector_recorder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          finish,
  input  logic          cap_valid,
  output logic          cap_ready,
  input  logic [15:0]   x,
  input  logic [15:0]   y,
  input  logic [15:0]   z,
  input  logic [1:0]    roundmode,
  input  logic          mul,
  input  logic          add,
  input  logic          negp,
  input  logic          negz,
  input  logic [15:0]   result,
  input  logic [3:0]    flags,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [75:0]   dump_data,
  output logic [AW:0]   count,
  output logic [31:0]   vectornum,
  output logic [31:0]   dropped,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [31:0]    vectornum_q, vectornum_d;
  logic [31:0]    dropped_q, dropped_d;
  logic [75:0]    mem_q [DEPTH];

  logic           full;
  logic           push;
  logic           pop;
  logic [75:0]    rec;

  assign rec        = {x, y, z, 2'b00, roundmode, mul, add, negp, negz, result, flags};
  assign full       = (count_q == FULL_CNT);
  assign cap_ready  = (state_q == S_RECORD) && !full;
  assign dump_valid = (count_q != '0);
  assign push       = cap_valid && cap_ready;
  assign pop        = dump_valid && dump_ready;

  // Gated so the port never shows uninitialised storage while empty.
  assign dump_data  = dump_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign vectornum  = vectornum_q;
  assign dropped    = dropped_q;
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    vectornum_d = vectornum_q;
    dropped_d   = dropped_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RECORD;
          vectornum_d = '0;
          dropped_d   = '0;
        end
      end
      S_RECORD: begin
        if (finish) state_d = S_DRAIN;
        if (push) vectornum_d = vectornum_q + 32'd1;
        if (cap_valid && full && (dropped_q != 32'hFFFF_FFFF))
          dropped_d = dropped_q + 32'd1;
      end
      S_DRAIN: begin
        if (count_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      vectornum_q <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      vectornum_q <= vectornum_d;
      dropped_q   <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= rec;
  end

endmodule

`default_nettype wire

// File: doc/fma16_vector_recorder.md
Name: fma16_vector_recorder

Overview:
- Writer-side counterpart of the fma16 vector-checking bench.
- Captures live fma16 operations (operands, control, result, flags) and packs each one into a 76-bit test-vector record in the bench's record format.
- Buffers records in an internal ring FIFO and streams them out on a valid/ready dump port to a trace sink or memory writer, so hardware runs can produce regression .tv files.

Parameters:
DEPTH, 16, FIFO entries (power of 2, ≥2)
AW, $clog2(DEPTH), pointer width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse: begin a recording session
finish  in  1  pulse: stop accepting, drain FIFO
cap_valid  in  1  operation sample present
cap_ready  out  1  recorder can accept sample
x, y, z  in  16 each  fma16 operands
roundmode  in  2  rounding mode
mul, add, negp, negz  in  1 each  fma16 op controls
result  in  16  fma16 result
flags  in  4  {invalid, overflow, underflow, inexact}
dump_valid  out  1  record available
dump_ready  in  1  sink accepts record
dump_data  out  76  packed record
count  out  AW+1  FIFO occupancy
vectornum  out  32  records accepted this session
dropped  out  32  samples offered while full in RECORD
done  out  1  session drained

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE; pointers, count, vectornum and dropped = 0.
  - cap_ready=0, dump_valid=0, done=0.
  - dump_data is don't-care while dump_valid=0.
- Record packing: dump_data = {x, y, z, ctrl, result, flags}, with ctrl = {2'b00, roundmode, mul, add, negp, negz}.
  - Bits [75:60]=x, [59:44]=y, [43:28]=z, [27:20]=ctrl, [19:4]=result, [3:0]=flags.
- FSM states: IDLE, RECORD, DRAIN, DONE.
  - IDLE: cap_ready=0. On start → RECORD and clear vectornum/dropped. FIFO contents are kept.
  - RECORD: cap_ready = (count != DEPTH).
    - Accept when cap_valid & cap_ready: write record at wr_ptr, wr_ptr++, vectornum++.
    - If cap_valid & count==DEPTH: dropped++ (saturates at 2^32-1).
    - On finish → DRAIN. If finish and a capture occur in the same cycle, the capture is accepted.
  - DRAIN: cap_ready=0. When count==0 → DONE.
  - DONE: done=1, cap_ready=0. On start → RECORD, clear vectornum/dropped, done falls next cycle.
  - start while in RECORD or DRAIN is ignored. finish outside RECORD is ignored.
  - start and finish together in IDLE or DONE: start wins.
- Dump side (all states):
  - dump_valid = (count != 0); dump_data = mem[rd_ptr] (show-ahead, no added latency).
  - On dump_valid & dump_ready: rd_ptr++.
  - dump_data is held stable while dump_valid=1 & dump_ready=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - cap_ready is based on the registered count only; there is no combinational pass-through from dump_ready.
  - When full, a pop and an offered sample in the same cycle still drop that sample.
- Latency: a record accepted at edge N is visible on dump_data after edge N (dump_valid high in the following cycle if the FIFO was empty).
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Reset mid-session: FIFO is emptied, in-flight records are discarded, state=IDLE.
- There are no X outputs after reset. The sink writes its own end-of-file terminator after done.

Test Plan:
- Basic pack: reset; start; one capture of x=3C00, y=4000, z=3C00, roundmode=01, mul=1, add=1, negp=0, negz=0, result=4200, flags=0 → dump_data=3C00_4000_3C00_1C_4200_0, vectornum=1, dump_valid the cycle after accept.
- Fill/backpressure: dump_ready=0; offer 20 consecutive samples, DEPTH=16 → cap_ready falls after 16 accepts, count=16, vectornum=16, dropped=4. Then drain with dump_ready=1 → 16 records in order, count returns to 0.
- Simultaneous push/pop: 8 stored, then capture and dump in the same cycle for 10 cycles → count stays 8, output order preserved across pointer wrap.
- Finish/drain: 5 stored; finish together with a 6th capture → 6th accepted. DRAIN ignores cap_valid. done=1 one cycle after the 6th record dumps.
- Restart: in DONE, pulse start → vectornum=0, dropped=0, done=0, cap_ready=1 next cycle.
- Reset mid-session: 4 stored, assert reset one cycle → count=0, dump_valid=0, cap_ready=0, state IDLE; the following start then works normally.
